// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on a request/acknowledge bus, stalls the
// pipeline while an access is in flight, and forwards the write-back triple to MEM_WB.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_sdata,
  output logic [31:0] mem_wdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  // Access size code: 0 none, 1 byte, 2 halfword, 3 word.
  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: op_size = 2'd1;
      4'd3, 4'd4, 4'd7: op_size = 2'd2;
      4'd5, 4'd8:       op_size = 2'd3;
      default:          op_size = 2'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == 4'd6) || (op == 4'd7) || (op == 4'd8);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd2:    misaligned = off[0];
      2'd3:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd1:    lane_sel = 4'b1000 >> off;
      2'd2:    lane_sel = off[1] ? 4'b0011 : 4'b1100;
      2'd3:    lane_sel = 4'b1111;
      default: lane_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd1:    store_data = {4{d[7:0]}};
      2'd2:    store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

  // Big-endian lane extraction: offset 0 is the most significant byte.
  function automatic logic [31:0] load_data(input logic [3:0] op, input logic [1:0] off,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (op)
      4'd1:    load_data = {{24{b[7]}}, b};
      4'd2:    load_data = {24'd0, b};
      4'd3:    load_data = {{16{h[15]}}, h};
      4'd4:    load_data = {16'd0, h};
      default: load_data = d;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          abort_q, abort_d;
  logic [3:0]    op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_sel_q, bus_sel_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;

  logic [31:0] mem_wdata_s;
  logic [4:0]  mem_wd_s;
  logic        mem_wreg_s;
  logic        stall_s;
  logic        align_s;
  logic        berr_s;
  logic [1:0]  size_s;

  assign size_s = op_size(ex_mem_op);

  // Next-state and stage outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    abort_d     = abort_q;
    op_d        = op_q;
    off_d       = off_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    mem_wdata_s = ex_wdata;
    mem_wd_s    = ex_wd;
    mem_wreg_s  = 1'b0;
    stall_s     = 1'b0;
    align_s     = 1'b0;
    berr_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (size_s == 2'd0) begin
          mem_wreg_s = ex_wreg;
        end else if (misaligned(size_s, ex_mem_addr[1:0])) begin
          align_s = 1'b1;
        end else begin
          stall_s     = 1'b1;
          state_d     = S_BUSY;
          cnt_d       = '0;
          abort_d     = 1'b0;
          op_d        = ex_mem_op;
          off_d       = ex_mem_addr[1:0];
          bus_req_d   = 1'b1;
          bus_we_d    = op_is_store(ex_mem_op);
          bus_addr_d  = {ex_mem_addr[31:2], 2'b00};
          bus_sel_d   = lane_sel(size_s, ex_mem_addr[1:0]);
          bus_wdata_d = store_data(size_s, ex_mem_sdata);
        end
      end
      S_BUSY: begin
        stall_s = 1'b1;
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (bus_ack) begin
          rdata_d   = bus_rdata;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          abort_d   = 1'b1;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort_q) begin
          berr_s = 1'b1;
        end else if (!op_is_store(op_q)) begin
          mem_wdata_s = load_data(op_q, off_q, rdata_q);
          mem_wreg_s  = ex_wreg;
        end else begin
          mem_wreg_s = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, capture and bus registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdata_q     <= 32'd0;
      abort_q     <= 1'b0;
      op_q        <= 4'd0;
      off_q       <= 2'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_sel_q   <= 4'd0;
      bus_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      abort_q     <= abort_d;
      op_q        <= op_d;
      off_q       <= off_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign mem_wdata = rst ? mem_wdata_s : 32'd0;
  assign mem_wd    = rst ? mem_wd_s    : 5'd0;
  assign mem_wreg  = rst & mem_wreg_s;
  assign stall_req = rst & stall_s;
  assign align_err = rst & align_s;
  assign bus_err   = rst & berr_s;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model sets per-cycle expectations
// that one negedge process compares, plus literal checks on key results.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ex_wdata = 32'd0;
  logic [4:0]  ex_wd = 5'd0;
  logic        ex_wreg = 1'b0;
  logic [3:0]  ex_mem_op = 4'd0;
  logic [31:0] ex_mem_addr = 32'd0;
  logic [31:0] ex_mem_sdata = 32'd0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ack = 1'b0;
  logic [31:0] mem_wdata, bus_addr, bus_wdata;
  logic [4:0]  mem_wd;
  logic [3:0]  bus_sel;
  logic        mem_wreg, stall_req, bus_req, bus_we, align_err, bus_err;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_wdata(ex_wdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .stall_req(stall_req),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected values for the current cycle
  logic        chk_en = 1'b0;
  logic        e_rst = 1'b1;
  logic        e_stall, e_req, e_align, e_berr, e_wreg, e_we, e_done;
  logic [31:0] e_wdata, e_addr, e_bwdata;
  logic [4:0]  e_wd;
  logic [3:0]  e_sel;

  // Observed statistics
  int          stall_cnt = 0;
  int          episodes = 0;
  int          align_cnt = 0;
  logic        prev_req = 1'b0;
  logic [31:0] done_wdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_size(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 1;
    if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 2;
    if (op == 4'd5 || op == 4'd8) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int size = model_size(op);
    int off = int'(addr % 32'd4);
    int shift = 8 * (4 - off - size);
    logic [31:0] mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    logic [31:0] v = (rd >> shift) & mask;
    if (op == 4'd1 && v >= 32'd128) v = v - 32'd256;
    if (op == 4'd3 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  // Single compare process for all DUT outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      if (e_rst) begin
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wd", {27'd0, mem_wd}, 32'd0);
        check("rst_flags", {26'd0, mem_wreg, stall_req, bus_req, bus_we, align_err, bus_err}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
      end else begin
        check("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
        check("bus_req", {31'd0, bus_req}, {31'd0, e_req});
        check("align_err", {31'd0, align_err}, {31'd0, e_align});
        check("bus_err", {31'd0, bus_err}, {31'd0, e_berr});
        check("mem_wreg", {31'd0, mem_wreg}, {31'd0, e_wreg});
        if (e_wreg) begin
          check("mem_wdata", mem_wdata, e_wdata);
          check("mem_wd", {27'd0, mem_wd}, {27'd0, e_wd});
        end
        if (e_req) begin
          check("bus_addr", bus_addr, e_addr);
          check("bus_we", {31'd0, bus_we}, {31'd0, e_we});
          check("bus_sel", {28'd0, bus_sel}, {28'd0, e_sel});
          if (e_we) check("bus_wdata", bus_wdata, e_bwdata);
        end
      end
      if (stall_req) stall_cnt++;
      if (align_err) align_cnt++;
      if (bus_req && !prev_req) episodes++;
      prev_req = bus_req;
      if (e_done) done_wdata = mem_wdata;
    end
  end

  task automatic clear_stats();
    stall_cnt = 0;
    episodes = 0;
    align_cnt = 0;
  endtask

  // One cycle with no memory op; called at posedge+1, returns at next posedge+1.
  task automatic idle_cycle(input logic [31:0] wdata, input logic [4:0] wd, input logic wreg,
                            input logic [3:0] op, input logic ack);
    ex_mem_op = op; ex_wdata = wdata; ex_wd = wd; ex_wreg = wreg; bus_ack = ack;
    e_stall = 1'b0; e_req = 1'b0; e_align = 1'b0; e_berr = 1'b0; e_done = 1'b0;
    e_wreg = wreg; e_wdata = wdata; e_wd = wd;
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  // Whole instruction: ack_at = BUSY cycle carrying bus_ack (1 = first), 0 = never.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] wd, input logic wreg, input int ack_at,
                       input logic [31:0] rdata);
    int size = model_size(op);
    int off = int'(addr % 32'd4);
    logic store = (op >= 4'd6) && (op <= 4'd8);
    logic aligned = (size == 0) || ((off % size) == 0);
    int nbusy = (ack_at > 0) ? ack_at : TO;
    ex_mem_op = op; ex_mem_addr = addr; ex_mem_sdata = sdata;
    ex_wdata = 32'h0BAD_0000 | addr; ex_wd = wd; ex_wreg = wreg;
    e_done = 1'b0; e_berr = 1'b0; e_req = 1'b0;
    e_stall = (size != 0) && aligned;
    e_align = (size != 0) && !aligned;
    e_wreg = (size == 0) ? wreg : 1'b0;
    e_wdata = ex_wdata; e_wd = wd;
    @(posedge clk); #1;
    if (size == 0 || !aligned) return;
    e_addr = addr & 32'hFFFF_FFFC;
    e_we = store;
    e_sel = (size == 1) ? (4'b1000 >> off) : (size == 2) ? (4'b1100 >> off) : 4'b1111;
    e_bwdata = (size == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
               (size == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
    for (int k = 1; k <= nbusy; k++) begin
      bus_ack = (k == ack_at);
      bus_rdata = (k == ack_at) ? rdata : 32'h5A5A_5A5A;
      e_stall = 1'b1; e_req = 1'b1; e_align = 1'b0; e_wreg = 1'b0;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0; bus_rdata = 32'hA5A5_A5A5;
    e_stall = 1'b0; e_req = 1'b0; e_done = 1'b1;
    e_berr = (ack_at == 0);
    e_wreg = (ack_at != 0) && !store && wreg;
    e_wdata = model_load(op, addr, rdata);
    @(posedge clk); #1;
    e_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Model pins
    check("model_LB", model_load(4'd1, 32'h101, 32'h11F2_3344), 32'hFFFF_FFF2);
    check("model_LBU", model_load(4'd2, 32'h101, 32'h11F2_3344), 32'h0000_00F2);
    check("model_LH", model_load(4'd3, 32'h202, 32'h1234_8001), 32'hFFFF_8001);

    // 1: reset and pass-through
    ex_wdata = 32'h1234_5678; ex_wd = 5'd5; ex_wreg = 1'b1;
    e_rst = 1'b1; chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; e_rst = 1'b0;
    idle_cycle(32'h1234_5678, 5'd5, 1'b1, 4'd0, 1'b0);
    idle_cycle(32'h0000_00AA, 5'd9, 1'b1, 4'd11, 1'b0);

    // 2: LB / LBU sign and zero extension
    clear_stats();
    do_op(4'd1, 32'h101, 32'd0, 5'd7, 1'b1, 2, 32'h11F2_3344);
    check("lb_done_wdata", done_wdata, 32'hFFFF_FFF2);
    check("lb_stall_cycles", stall_cnt, 32'd3);
    check("lb_req_episodes", episodes, 32'd1);
    do_op(4'd2, 32'h101, 32'd0, 5'd7, 1'b1, 2, 32'h11F2_3344);
    check("lbu_done_wdata", done_wdata, 32'h0000_00F2);
    do_op(4'd3, 32'h202, 32'd0, 5'd3, 1'b1, 1, 32'h1234_8001);
    do_op(4'd4, 32'h200, 32'd0, 5'd4, 1'b1, 3, 32'h8001_2345);
    check("lhu_done_wdata", done_wdata, 32'h0000_8001);
    do_op(4'd2, 32'h303, 32'd0, 5'd6, 1'b1, 1, 32'h0000_0080);

    // 3: stores
    clear_stats();
    do_op(4'd7, 32'h202, 32'hAAAA_BEEF, 5'd2, 1'b1, 1, 32'd0);
    check("sh_req_episodes", episodes, 32'd1);
    check("sh_stall_cycles", stall_cnt, 32'd2);
    do_op(4'd6, 32'h403, 32'h1234_5678, 5'd2, 1'b1, 2, 32'd0);
    do_op(4'd8, 32'h500, 32'hDEAD_BEEF, 5'd2, 1'b0, 1, 32'd0);

    // 4: misaligned LW
    clear_stats();
    do_op(4'd5, 32'h3, 32'd0, 5'd8, 1'b1, 1, 32'd0);
    idle_cycle(32'h1, 5'd1, 1'b1, 4'd0, 1'b0);
    check("misalign_no_req", episodes, 32'd0);
    check("misalign_pulses", align_cnt, 32'd1);
    check("misalign_no_stall", stall_cnt, 32'd0);

    // 5: timeout abort, then a stray ack in IDLE
    clear_stats();
    do_op(4'd5, 32'h40, 32'd0, 5'd9, 1'b1, 0, 32'd0);
    check("timeout_stall_cycles", stall_cnt, 32'd5);
    idle_cycle(32'h77, 5'd3, 1'b1, 4'd0, 1'b1);
    idle_cycle(32'h78, 5'd3, 1'b1, 4'd0, 1'b0);
    check("stray_ack_no_req", episodes, 32'd1);

    // 6: reset mid-access
    ex_mem_op = 4'd5; ex_mem_addr = 32'h20; ex_wd = 5'd1; ex_wreg = 1'b1;
    e_stall = 1'b1; e_req = 1'b0; e_wreg = 1'b0; e_align = 1'b0; e_berr = 1'b0;
    @(posedge clk); #1;
    e_req = 1'b1; e_addr = 32'h20; e_we = 1'b0; e_sel = 4'b1111;
    @(posedge clk); #3;
    rst = 1'b0; e_rst = 1'b1; ex_mem_op = 4'd0;
    #1;
    check("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("async_rst_stall", {31'd0, stall_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; e_rst = 1'b0;
    idle_cycle(32'h99, 5'd4, 1'b1, 4'd0, 1'b0);
    do_op(4'd5, 32'h10, 32'd0, 5'd12, 1'b1, 1, 32'hCAFE_BABE);
    check("post_rst_lw", done_wdata, 32'hCAFE_BABE);
    idle_cycle(32'h0, 5'd0, 1'b0, 4'd0, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the 5-stage CPU core.
- Sits between the EX/MEM register and the MEM_WB register, and performs loads and stores over a single-master request/acknowledge data bus of variable latency.
- Holds the pipeline with stall_req while an access is outstanding.
- Forwards the write-back triple (wdata, wd, wreg) to the MEM_WB register.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in BUSY without bus_ack before the access is aborted. 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- ex_wdata  input  32  ALU result from EX/MEM (write data for non-memory ops).
- ex_wd  input  5  destination register.
- ex_wreg  input  1  register write enable.
- ex_mem_op  input  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW. Values 9-15 are treated as none.
- ex_mem_addr  input  32  effective byte address.
- ex_mem_sdata  input  32  store data (rt).
- mem_wdata  output  32  write-back data to MEM_WB.
- mem_wd  output  5  destination register to MEM_WB.
- mem_wreg  output  1  write enable to MEM_WB.
- stall_req  output  1  pipeline hold request to the stall controller.
- bus_req  output  1  bus request.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word address (ex_mem_addr with bits [1:0] forced to 0).
- bus_sel  output  4  byte lanes, bit 3 = bits [31:24].
- bus_wdata  output  32  lane-replicated store data.
- bus_rdata  input  32  read data, valid with bus_ack.
- bus_ack  input  1  one-cycle completion strobe.
- align_err  output  1  one-cycle pulse on a misaligned access.
- bus_err  output  1  one-cycle pulse on a timeout abort.

Behaviour:

Reset (rst=0, asynchronous):
- state=IDLE, timeout counter=0, captured data=0.
- All outputs 0.
- mem_wd=NOP register address (0).

State machine: IDLE, BUSY, DONE.

IDLE, ex_mem_op none:
- mem_wdata/mem_wd/mem_wreg = ex_wdata/ex_wd/ex_wreg (combinational pass-through).
- stall_req=0, bus_req=0.

IDLE, valid memory op, aligned:
- Alignment rule: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
- Registers bus_addr/bus_we/bus_sel/bus_wdata, asserts bus_req, moves to BUSY.
- stall_req=1 combinationally in the same cycle.
- mem_wreg=0 while stalled.

IDLE, misaligned:
- No bus cycle.
- align_err pulses for that cycle, mem_wreg=0, stall_req=0.
- The instruction retires with no effect.

BUSY:
- bus_req=1. bus_addr/bus_sel/bus_we/bus_wdata are held stable.
- stall_req=1, mem_wreg=0. The counter increments each cycle.
- On bus_ack: capture bus_rdata, drop bus_req on the next edge, go to DONE.
- If the counter reaches TIMEOUT_CYCLES first (and TIMEOUT_CYCLES≠0): drop bus_req, set an abort flag, go to DONE.

DONE (exactly one cycle):
- stall_req=0, so the pipeline advances at the end of this cycle.
- Loads: mem_wdata = extracted value, mem_wd = ex_wd, mem_wreg = ex_wreg.
- Stores: mem_wreg=0.
- After an abort: mem_wreg=0 and bus_err pulses.
- Next state is IDLE. The same instruction is never reissued.

Byte lanes (big-endian):
- addr[1:0]=0 → bus_sel 1000, data bits [31:24]; addr[1:0]=3 → bus_sel 0001, data bits [7:0].
- Halfword: addr[1]=0 → bus_sel 1100; addr[1]=1 → bus_sel 0011.
- Word → bus_sel 1111.
- Store data is replicated: SB = {4{b}}, SH = {2{h}}.
- Load extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.

Bus protocol and latency:
- bus_ack outside BUSY is ignored.
- bus_ack in the first BUSY cycle is legal.
- Minimum memory-op latency is 3 cycles (IDLE issue, BUSY ack, DONE): 2 stall cycles.

Reset mid-access:
- Returns to IDLE immediately and drops bus_req asynchronously.
- The access is abandoned with no write-back.

Test Plan:
1. Reset and pass-through: rst low then high with op=0, ex_wdata=0x12345678, wd=5, wreg=1 → mem_wdata=0x12345678, mem_wd=5, mem_wreg=1, stall_req=0 in the same cycle. All outputs are 0 during reset.
2. LB sign-extend: LB addr=0x101, ack after 2 BUSY cycles with bus_rdata=0x11F2_3344 → bus_addr=0x100, bus_sel=0100, stall_req high for 3 cycles, DONE shows mem_wdata=0xFFFFFFF2, mem_wreg=1. LBU with the same inputs → 0x000000F2.
3. SH upper half: SH addr=0x202, sdata=0xAAAA_BEEF, immediate ack → bus_we=1, bus_sel=0011, bus_wdata=0xBEEFBEEF, mem_wreg=0 in DONE, exactly one bus_req episode.
4. Misaligned LW: LW addr=0x3 → align_err for 1 cycle, bus_req never asserted, mem_wreg=0, stall_req=0.
5. Timeout abort: TIMEOUT_CYCLES=4, LW with bus_ack never asserted → bus_req drops after 4 BUSY cycles, bus_err pulses in DONE, mem_wreg=0, state returns to IDLE. A stray bus_ack in IDLE afterwards has no effect.
6. Reset mid-access: assert rst in BUSY → bus_req and stall_req go to 0 asynchronously. After release, a new LW addr=0x10 with ack and bus_rdata=0xCAFEBABE completes normally with mem_wdata=0xCAFEBABE.
